note_sequencer: RTL and testbench

Step sequencer that drives the square-wave tone divider with a programmable series of half-period values. Holds a small note table written by the host, and on `start` presents one table entry per fixed-length step on `period`, with a load strobe and gate. Sits between host/control logic and the tone divider: the divider compares its free-running count against `period`, and `gate` masks the speaker output.

---
 rtl/note_sequencer.sv | 85 ++++++++
 tb/tb_note_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: host-programmed step sequencer feeding half-period values to the tone divider; SEQ_LOOP_EN enables looping playback.
module note_sequencer #(
  parameter int PERIOD_W = 32,
  parameter int STEPS    = 4,
  parameter int ADDR_W   = 2,
  parameter int STEP_LEN = 10000000,
  parameter int LEN_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PERIOD_W-1:0] wr_data,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   last_step,
  output logic                busy,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                gate,
  output logic [ADDR_W-1:0]   step_idx,
  output logic                done
);
  localparam logic IDLE = 1'b0;
  localparam logic PLAY = 1'b1;
  localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(STEP_LEN - 1);
  logic                state;
  logic [LEN_W-1:0]    cnt;
  logic [ADDR_W-1:0]   last_l, last_c, nidx;
  logic                loop_l;
  logic [PERIOD_W-1:0] tbl [STEPS];
  logic                go, at_end, adv, fin, enter;
  assign busy   = state;
  assign last_c = (32'(last_step) > STEPS - 1) ? ADDR_W'(STEPS - 1) : last_step;
  assign go     = state == IDLE && start && !stop;
  assign at_end = state == PLAY && !stop && cnt == LAST_CNT;
  assign adv    = at_end && (step_idx != last_l || loop_l);
  assign fin    = at_end && !adv;
  assign enter  = go || adv;
  assign nidx   = (go || step_idx == last_l) ? '0 : step_idx + ADDR_W'(1);
`ifdef SEQ_LOOP_EN
  always_ff @(posedge clk)
    if (rst) loop_l <= 1'b0;
    else if (go) loop_l <= loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_l = 1'b0;
`endif
  // table is sampled only on step entry, so a same-cycle write to that entry is seen next visit
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      step_idx     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      gate         <= 1'b0;
      done         <= 1'b0;
      last_l       <= '0;
      for (int i = 0; i < STEPS; i++) tbl[i] <= '0;
    end else begin
      if (wr_en && 32'(wr_addr) < STEPS) tbl[wr_addr] <= wr_data;
      period_valid <= enter;
      done         <= fin;
      if (go) last_l <= last_c;
      if (enter) begin
        state    <= PLAY;
        step_idx <= nidx;
        period   <= tbl[nidx];
        gate     <= tbl[nidx] != '0;
        cnt      <= '0;
      end else if (state == PLAY && (stop || fin)) begin
        state    <= IDLE;
        step_idx <= '0;
        period   <= '0;
        gate     <= 1'b0;
        cnt      <= '0;
      end else if (state == PLAY) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scoreboard bench for note_sequencer with STEPS=4, STEP_LEN=4.
module tb_note_sequencer;
  typedef struct packed {
    logic        busy;
    logic [31:0] period;
    logic        pv;
    logic        gate;
    logic [1:0]  idx;
    logic        done;
  } exp_t;
  logic        clk = 0, rst = 1, wr_en = 0, start = 0, stop = 0, loop = 0;
  logic [1:0]  wr_addr = 0, last_step = 0;
  logic [31:0] wr_data = 0;
  logic        busy, period_valid, gate, done;
  logic [31:0] period;
  logic [1:0]  step_idx;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  note_sequencer #(.PERIOD_W(32), .STEPS(4), .ADDR_W(2), .STEP_LEN(4), .LEN_W(32)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .last_step(last_step),
    .busy(busy), .period(period), .period_valid(period_valid), .gate(gate),
    .step_idx(step_idx), .done(done)
  );
  always #5 clk = ~clk;
  task automatic cyc(input exp_t e, input string tag);
    exp_t got, want;
    q.push_back(e);
    @(posedge clk);
    #1;
    rst = 0; start = 0; stop = 0; wr_en = 0;
    got  = {busy, period, period_valid, gate, step_idx, done};
    want = q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got busy=%0b period=%0d pv=%0b gate=%0b idx=%0d done=%0b exp busy=%0b period=%0d pv=%0b gate=%0b idx=%0d done=%0b",
             tag, got.busy, got.period, got.pv, got.gate, got.idx, got.done,
             want.busy, want.period, want.pv, want.gate, want.idx, want.done);
    end
  endtask
  task automatic idle(input logic d, input string tag);
    cyc('{1'b0, 32'd0, 1'b0, 1'b0, 2'd0, d}, tag);
  endtask
  task automatic step(input logic [31:0] p, input logic [1:0] k, input int n, input logic entering, input string tag);
    for (int i = 0; i < n; i++)
      cyc('{1'b1, p, entering && i == 0, p != 0, k, 1'b0}, tag);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask
  initial begin
    idle(0, "reset");
    wr(0, 191116); idle(0, "wr0");
    wr(1, 340529); idle(0, "wr1");
    wr(2, 286352); idle(0, "wr2");
    wr(3, 227272); idle(0, "wr3");
    last_step = 3; loop = 0; start = 1;
    step(191116, 0, 4, 1, "one_s0");
    step(340529, 1, 4, 1, "one_s1");
    step(286352, 2, 4, 1, "one_s2");
    step(227272, 3, 4, 1, "one_s3");
    idle(1, "one_done");
    idle(0, "one_after");
    wr(1, 0); idle(0, "wr_rest");
    start = 1;
    step(191116, 0, 4, 1, "rest_s0");
    step(0, 1, 4, 1, "rest_s1");
    step(286352, 2, 4, 1, "rest_s2");
    step(227272, 3, 4, 1, "rest_s3");
    idle(1, "rest_done");
    loop = 1; last_step = 1; start = 1;
`ifdef SEQ_LOOP_EN
    for (int r = 0; r < 5; r++) begin
      step(191116, 0, 4, 1, "loop_s0");
      step(0, 1, 4, 1, "loop_s1");
    end
    step(191116, 0, 2, 1, "loop_s0_last");
    stop = 1; idle(0, "loop_stop");
`else
    step(191116, 0, 4, 1, "noloop_s0");
    step(0, 1, 4, 1, "noloop_s1");
    idle(1, "noloop_done");
`endif
    loop = 0; last_step = 3; start = 1;
    step(191116, 0, 4, 1, "bnd_s0");
    stop = 1; idle(0, "bnd_stop");
    idle(0, "bnd_after");
    start = 1; stop = 1; idle(0, "start_stop");
    idle(0, "start_stop_after");
    start = 1;
    step(191116, 0, 2, 1, "wip_s0a");
    wr(0, 100);
    step(191116, 0, 1, 0, "wip_s0b");
    step(191116, 0, 1, 0, "wip_s0c");
    step(0, 1, 4, 1, "wip_s1");
    step(286352, 2, 4, 1, "wip_s2");
    step(227272, 3, 4, 1, "wip_s3");
    idle(1, "wip_done");
    start = 1;
    step(100, 0, 4, 1, "wip_new0");
    step(0, 1, 4, 1, "wip_new1");
    step(286352, 2, 2, 1, "rst_s2");
    rst = 1; idle(0, "rst_mid");
    start = 1;
    step(0, 0, 4, 1, "rst_cleared0");
    step(0, 1, 1, 1, "rst_cleared1");
    stop = 1; idle(0, "final_stop");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
